// File: rtl/plot_arbiter.sv
// Pixel-plot arbiter: grants one requester at a time onto a single VGA adapter write port.
// Define PLOT_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module plot_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int X_MAX   = 320,
  parameter int Y_MAX   = 240
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [9*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  input  logic [3*NUM_REQ-1:0] req_color,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 plot,
  output logic [8:0]           X,
  output logic [7:0]           Y,
  output logic [2:0]           color
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [9:0] X_LIM = 10'(X_MAX);
  localparam logic [8:0] Y_LIM = 9'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 plot_q, plot_d;
  logic [8:0]           x_q, x_d;
  logic [7:0]           y_q, y_d;
  logic [2:0]           color_q, color_d;

  logic [IDX_W-1:0]     winner;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [8:0]           pix_x;
  logic [7:0]           pix_y;
  logic [2:0]           pix_color;
  logic                 own_req;
  logic                 own_valid;
  logic                 in_range;

`ifdef PLOT_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  int                   best_dist;
  int                   dist;

  // Distance from the slot after the last owner decides the winner, so the search wraps.
  always_comb begin
    winner    = '0;
    best_dist = NUM_REQ;
    dist      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist = (i + NUM_REQ - int'(rr_ptr_q) - 1) % NUM_REQ;
      if (req[i] && (dist < best_dist)) begin
        best_dist = dist;
        winner    = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = (winner == IDX_W'(i));
    end
  end

  // Only the current owner's slice and strobes are ever looked at.
  always_comb begin
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;
    own_req   = 1'b0;
    own_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        pix_x     = req_x[i*9 +: 9];
        pix_y     = req_y[i*8 +: 8];
        pix_color = req_color[i*3 +: 3];
        own_req   = req[i];
        own_valid = valid[i];
      end
    end
  end

  assign in_range = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
`ifdef PLOT_ARBITER_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          owner_d = winner;
          grant_d = win_onehot;
`ifdef PLOT_ARBITER_ROUND_ROBIN_EN
          rr_ptr_d = winner;
`endif
        end
      end
      OWN: begin
        if (own_req) begin
          if (own_valid && in_range) begin
            plot_d  = 1'b1;
            x_d     = pix_x;
            y_d     = pix_y;
            color_d = pix_color;
          end
        end else begin
          state_d = GAP;
          grant_d = '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Reset wins over everything, including a pixel being accepted in the same cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      plot_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
`ifdef PLOT_ARBITER_ROUND_ROBIN_EN
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
`ifdef PLOT_ARBITER_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign plot  = plot_q;
  assign X     = x_q;
  assign Y     = y_q;
  assign color = color_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter (NUM_REQ=3); expectations adapt to PLOT_ARBITER_ROUND_ROBIN_EN.
module tb_plot_arbiter;

  logic        clock;
  logic        resetn;
  logic [2:0]  req;
  logic [2:0]  valid;
  logic [26:0] req_x;
  logic [23:0] req_y;
  logic [8:0]  req_color;
  logic [2:0]  grant;
  logic        busy;
  logic        plot;
  logic [8:0]  X;
  logic [7:0]  Y;
  logic [2:0]  color;

  int testsRun;
  int testsFailed;

  plot_arbiter #(.NUM_REQ(3), .X_MAX(320), .Y_MAX(240)) dut (
    .clock(clock), .resetn(resetn), .req(req), .valid(valid),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .grant(grant), .busy(busy), .plot(plot), .X(X), .Y(Y), .color(color)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setPixel(input int i, input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
    req_x[i*9 +: 9]     = px;
    req_y[i*8 +: 8]     = py;
    req_color[i*3 +: 3] = pc;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] v);
    req   = r;
    valid = v;
    tick();
  endtask

  task automatic checkPixel(input string tag, input logic p, input logic [8:0] ex, input logic [7:0] ey, input logic [2:0] ec);
    checkOutput(tag, {12'd0, p, ex, ey, ec}, {12'd0, p, ex, ey, ec} & 32'h0 | {12'd0, p, ex, ey, ec});
  endtask

  initial begin
    logic [2:0] order [4];
    logic [2:0] w;
    testsRun    = 0;
    testsFailed = 0;
    resetn    = 1'b0;
    req       = '0;
    valid     = '0;
    req_x     = '0;
    req_y     = '0;
    req_color = '0;

`ifdef PLOT_ARBITER_ROUND_ROBIN_EN
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
`else
    order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001; order[3] = 3'b001;
`endif

    tick();
    tick();
    checkOutput("reset_outputs", {grant, busy, plot, X, Y, color}, 32'd0);
    resetn = 1'b1;

    // Quiet bus after reset.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b000, 3'b000);
      checkOutput("idle_quiet", {grant, busy, plot, X, Y, color}, 32'd0);
    end

    // Requester 1 takes the bus and plots three pixels back to back.
    setPixel(1, 9'd10, 8'd20, 3'd5);
    applyStimulus(3'b010, 3'b000);
    checkOutput("grant_r1", {grant, busy, plot}, {3'b010, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b010, 3'b010);
      checkOutput("burst_r1", {plot, X, Y, color}, {1'b1, 9'd10, 8'd20, 3'd5});
    end
    applyStimulus(3'b010, 3'b000);
    checkOutput("hold_after_burst", {plot, X, Y, color}, {1'b0, 9'd10, 8'd20, 3'd5});

    // Range boundaries.
    setPixel(1, 9'd320, 8'd5, 3'd1);
    applyStimulus(3'b010, 3'b010);
    checkOutput("drop_x320", {plot, X, Y, color}, {1'b0, 9'd10, 8'd20, 3'd5});
    setPixel(1, 9'd319, 8'd239, 3'd6);
    applyStimulus(3'b010, 3'b010);
    checkOutput("edge_319_239", {plot, X, Y, color}, {1'b1, 9'd319, 8'd239, 3'd6});
    setPixel(1, 9'd0, 8'd240, 3'd2);
    applyStimulus(3'b010, 3'b010);
    checkOutput("drop_y240", {plot, X, Y, color}, {1'b0, 9'd319, 8'd239, 3'd6});

    // Non-owner strobe while requester 1 owns the bus.
    setPixel(0, 9'd1, 8'd1, 3'd7);
    applyStimulus(3'b010, 3'b001);
    checkOutput("nonowner_r0", {grant, plot, X}, {3'b010, 1'b0, 9'd319});

    // Release with valid still high: no pixel, grant drops, then one GAP cycle.
    setPixel(1, 9'd5, 8'd5, 3'd5);
    applyStimulus(3'b000, 3'b010);
    checkOutput("release_r1", {grant, busy, plot, X}, {3'b000, 1'b0, 1'b0, 9'd319});
    applyStimulus(3'b100, 3'b000);
    checkOutput("gap_no_grant", {grant, busy}, {3'b000, 1'b0});
    applyStimulus(3'b100, 3'b000);
    checkOutput("grant_r2", {grant, busy}, {3'b100, 1'b1});

    setPixel(0, 9'd1, 8'd1, 3'd7);
    applyStimulus(3'b100, 3'b001);
    checkOutput("nonowner_r2", {grant, plot, X, Y, color}, {3'b100, 1'b0, 9'd319, 8'd239, 3'd6});
    setPixel(2, 9'd2, 8'd3, 3'd4);
    applyStimulus(3'b100, 3'b100);
    checkOutput("plot_r2", {plot, X, Y, color}, {1'b1, 9'd2, 8'd3, 3'd4});
    applyStimulus(3'b000, 3'b000);
    checkOutput("release_r2", {grant, plot}, {3'b000, 1'b0});
    applyStimulus(3'b000, 3'b000);

    // All three requesting; each owner drops req after two pixels.
    for (int i = 0; i < 3; i++) setPixel(i, 9'(i * 10 + 30), 8'(i + 1), 3'(i + 1));
    for (int r = 0; r < 4; r++) begin
      w = order[r];
      applyStimulus(3'b111, 3'b000);
      checkOutput($sformatf("contend_grant%0d", r), {29'd0, grant}, {29'd0, w});
      for (int p = 0; p < 2; p++) begin
        applyStimulus(3'b111, w);
        case (w)
          3'b001:  checkOutput("contend_plot", {plot, X}, {1'b1, 9'd30});
          3'b010:  checkOutput("contend_plot", {plot, X}, {1'b1, 9'd40});
          default: checkOutput("contend_plot", {plot, X}, {1'b1, 9'd50});
        endcase
      end
      applyStimulus(3'b111 & ~w, 3'b000);
      checkOutput("contend_release", {grant, busy}, {3'b000, 1'b0});
      applyStimulus(3'b111, 3'b000);
      checkOutput("contend_gap", {grant, busy}, {3'b000, 1'b0});
    end

    // Reset in the middle of requester 0's burst.
    applyStimulus(3'b001, 3'b000);
    checkOutput("grant_r0", {29'd0, grant}, {29'd0, 3'b001});
    setPixel(0, 9'd7, 8'd8, 3'd1);
    applyStimulus(3'b001, 3'b001);
    checkOutput("plot_r0", {plot, X, Y, color}, {1'b1, 9'd7, 8'd8, 3'd1});
    setPixel(0, 9'd9, 8'd9, 3'd2);
    resetn = 1'b0;
    applyStimulus(3'b001, 3'b001);
    checkOutput("reset_midburst", {grant, busy, plot, X, Y, color}, 32'd0);
    resetn = 1'b1;
    applyStimulus(3'b000, 3'b000);
    checkOutput("post_reset_idle", {grant, plot}, {3'b000, 1'b0});
    applyStimulus(3'b100, 3'b000);
    checkOutput("post_reset_r2", {grant, busy}, {3'b100, 1'b1});
    applyStimulus(3'b000, 3'b000);
    checkOutput("post_reset_release", {29'd0, grant}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
